// File: rtl/sram_test_core.sv
// sram_test_core: BIST controller for an external 256K x 32 async SRAM (write pattern, read back, compare).
// Define SRAM_TEST_LOOP_EN to run passes forever, inverting the pattern on alternate passes.
module sram_test_core #(
  parameter logic [17:0] ADDR_LAST     = 18'h3FFFF,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic CLK_48MHZ,
  input  logic RESET_IN_L8,
  output logic SRAM_A0, SRAM_A1, SRAM_A2, SRAM_A3, SRAM_A4, SRAM_A5, SRAM_A6, SRAM_A7, SRAM_A8,
               SRAM_A9, SRAM_A10, SRAM_A11, SRAM_A12, SRAM_A13, SRAM_A14, SRAM_A15, SRAM_A16, SRAM_A17,
  output logic SRAM_SRBS0, SRAM_SRBS1, SRAM_SRBS2, SRAM_SRBS3,
  output logic SRAM_CE,
  output logic SRAM_WE,
  output logic SRAM_OE,
  output logic D0, D1, D2, D3, D4, D5, D6, D7,
  inout  wire  SRAM_D0, SRAM_D1, SRAM_D2, SRAM_D3, SRAM_D4, SRAM_D5, SRAM_D6, SRAM_D7,
               SRAM_D8, SRAM_D9, SRAM_D10, SRAM_D11, SRAM_D12, SRAM_D13, SRAM_D14, SRAM_D15,
               SRAM_D16, SRAM_D17, SRAM_D18, SRAM_D19, SRAM_D20, SRAM_D21, SRAM_D22, SRAM_D23,
               SRAM_D24, SRAM_D25, SRAM_D26, SRAM_D27, SRAM_D28, SRAM_D29, SRAM_D30, SRAM_D31
);
  localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_WAIT, R_END, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [17:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       err_q, err_d;
  logic             inv_q, inv_d;
  logic             done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic             ce_q, ce_d, we_q, we_d, oe_q, oe_d, drv_q, drv_d, busy_d;
  logic [3:0]       srbs_q, srbs_d;
  logic [31:0]      wd_q, wd_d;
  logic [7:0]       status_q, status_d;
  logic [31:0]      rd_data_c, exp_c;
  logic             mismatch_c;

  function automatic logic [31:0] pattern(input logic [17:0] a, input logic inv);
    return {~a[13:0], a} ^ {32{inv}};
  endfunction

  assign rd_data_c = {SRAM_D31, SRAM_D30, SRAM_D29, SRAM_D28, SRAM_D27, SRAM_D26, SRAM_D25, SRAM_D24,
                      SRAM_D23, SRAM_D22, SRAM_D21, SRAM_D20, SRAM_D19, SRAM_D18, SRAM_D17, SRAM_D16,
                      SRAM_D15, SRAM_D14, SRAM_D13, SRAM_D12, SRAM_D11, SRAM_D10, SRAM_D9,  SRAM_D8,
                      SRAM_D7,  SRAM_D6,  SRAM_D5,  SRAM_D4,  SRAM_D3,  SRAM_D2,  SRAM_D1,  SRAM_D0};
  assign exp_c = pattern(addr_q, inv_q);

  // An unknown comparison falls into the else branch, so X/Z read bits count as errors.
  always_comb begin
    if (rd_data_c == exp_c) mismatch_c = 1'b0;
    else                    mismatch_c = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge CLK_48MHZ or negedge RESET_IN_L8) begin
    if (!RESET_IN_L8) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      inv_q    <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      ce_q     <= 1'b1;
      we_q     <= 1'b1;
      oe_q     <= 1'b1;
      drv_q    <= 1'b0;
      srbs_q   <= 4'hF;
      wd_q     <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      inv_q    <= inv_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      ce_q     <= ce_d;
      we_q     <= we_d;
      oe_q     <= oe_d;
      drv_q    <= drv_d;
      srbs_q   <= srbs_d;
      wd_q     <= wd_d;
      status_q <= status_d;
    end
  end

  // Next-state, address sequencing and error accumulation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    inv_d   = inv_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        state_d = W_SETUP;
        addr_d  = '0;
      end
      W_SETUP: begin
        state_d = W_PULSE;
        cnt_d   = '0;
      end
      W_PULSE: begin
        if (cnt_q == CNT_LAST) state_d = W_HOLD;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      W_HOLD: begin
        if (addr_q == ADDR_LAST) begin
          state_d = R_SETUP;
          addr_d  = '0;
        end else begin
          state_d = W_SETUP;
          addr_d  = addr_q + 18'd1;
        end
      end
      R_SETUP: begin
        state_d = R_WAIT;
        cnt_d   = '0;
      end
      R_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = R_END;
          if (mismatch_c && (err_q != 4'hF)) err_d = err_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      R_END: begin
        if (addr_q == ADDR_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (err_q == 4'd0);
          fail_d  = (err_q != 4'd0);
        end else begin
          state_d = R_SETUP;
          addr_d  = addr_q + 18'd1;
        end
      end
`ifdef SRAM_TEST_LOOP_EN
      DONE: begin
        state_d = W_SETUP;
        addr_d  = '0;
        inv_d   = ~inv_q;
      end
`else
      DONE: state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they register in step with it.
  always_comb begin
    ce_d   = 1'b1;
    we_d   = 1'b1;
    oe_d   = 1'b1;
    srbs_d = 4'hF;
    drv_d  = 1'b0;
    busy_d = 1'b1;
    wd_d   = pattern(addr_d, inv_d);
    case (state_d)
      W_SETUP, W_HOLD: begin
        ce_d   = 1'b0;
        srbs_d = 4'h0;
        drv_d  = 1'b1;
      end
      W_PULSE: begin
        ce_d   = 1'b0;
        srbs_d = 4'h0;
        drv_d  = 1'b1;
        we_d   = 1'b0;
      end
      R_SETUP, R_WAIT: begin
        ce_d   = 1'b0;
        srbs_d = 4'h0;
        oe_d   = 1'b0;
      end
      R_END: begin
        ce_d   = 1'b0;
        srbs_d = 4'h0;
      end
      default: busy_d = 1'b0;
    endcase
    status_d = {done_d, pass_d, fail_d, busy_d, err_d};
  end

  assign {SRAM_A17, SRAM_A16, SRAM_A15, SRAM_A14, SRAM_A13, SRAM_A12, SRAM_A11, SRAM_A10, SRAM_A9,
          SRAM_A8, SRAM_A7, SRAM_A6, SRAM_A5, SRAM_A4, SRAM_A3, SRAM_A2, SRAM_A1, SRAM_A0} = addr_q;
  assign {SRAM_SRBS3, SRAM_SRBS2, SRAM_SRBS1, SRAM_SRBS0} = srbs_q;
  assign SRAM_CE = ce_q;
  assign SRAM_WE = we_q;
  assign SRAM_OE = oe_q;
  assign {D7, D6, D5, D4, D3, D2, D1, D0} = status_q;

  // Per-bit tristate drivers; the bus is released whenever drv_q is low.
  assign SRAM_D0  = drv_q ? wd_q[0]  : 1'bz;  assign SRAM_D1  = drv_q ? wd_q[1]  : 1'bz;
  assign SRAM_D2  = drv_q ? wd_q[2]  : 1'bz;  assign SRAM_D3  = drv_q ? wd_q[3]  : 1'bz;
  assign SRAM_D4  = drv_q ? wd_q[4]  : 1'bz;  assign SRAM_D5  = drv_q ? wd_q[5]  : 1'bz;
  assign SRAM_D6  = drv_q ? wd_q[6]  : 1'bz;  assign SRAM_D7  = drv_q ? wd_q[7]  : 1'bz;
  assign SRAM_D8  = drv_q ? wd_q[8]  : 1'bz;  assign SRAM_D9  = drv_q ? wd_q[9]  : 1'bz;
  assign SRAM_D10 = drv_q ? wd_q[10] : 1'bz;  assign SRAM_D11 = drv_q ? wd_q[11] : 1'bz;
  assign SRAM_D12 = drv_q ? wd_q[12] : 1'bz;  assign SRAM_D13 = drv_q ? wd_q[13] : 1'bz;
  assign SRAM_D14 = drv_q ? wd_q[14] : 1'bz;  assign SRAM_D15 = drv_q ? wd_q[15] : 1'bz;
  assign SRAM_D16 = drv_q ? wd_q[16] : 1'bz;  assign SRAM_D17 = drv_q ? wd_q[17] : 1'bz;
  assign SRAM_D18 = drv_q ? wd_q[18] : 1'bz;  assign SRAM_D19 = drv_q ? wd_q[19] : 1'bz;
  assign SRAM_D20 = drv_q ? wd_q[20] : 1'bz;  assign SRAM_D21 = drv_q ? wd_q[21] : 1'bz;
  assign SRAM_D22 = drv_q ? wd_q[22] : 1'bz;  assign SRAM_D23 = drv_q ? wd_q[23] : 1'bz;
  assign SRAM_D24 = drv_q ? wd_q[24] : 1'bz;  assign SRAM_D25 = drv_q ? wd_q[25] : 1'bz;
  assign SRAM_D26 = drv_q ? wd_q[26] : 1'bz;  assign SRAM_D27 = drv_q ? wd_q[27] : 1'bz;
  assign SRAM_D28 = drv_q ? wd_q[28] : 1'bz;  assign SRAM_D29 = drv_q ? wd_q[29] : 1'bz;
  assign SRAM_D30 = drv_q ? wd_q[30] : 1'bz;  assign SRAM_D31 = drv_q ? wd_q[31] : 1'bz;

endmodule

// File: tb/tb_sram_test_core.sv
// tb_sram_test_core: scoreboard bench for sram_test_core with a 16-word behavioural SRAM on the bus.
module tb_sram_test_core;
  localparam logic [17:0] ADDR_LAST = 18'd15;
  localparam int unsigned ACC       = 2;

  // Hand-computed {~addr[13:0], addr[17:0]} for addresses 0..15.
  localparam logic [31:0] WDATA [16] = '{
    32'hFFFC_0000, 32'hFFF8_0001, 32'hFFF4_0002, 32'hFFF0_0003,
    32'hFFEC_0004, 32'hFFE8_0005, 32'hFFE4_0006, 32'hFFE0_0007,
    32'hFFDC_0008, 32'hFFD8_0009, 32'hFFD4_000A, 32'hFFD0_000B,
    32'hFFCC_000C, 32'hFFC8_000D, 32'hFFC4_000E, 32'hFFC0_000F};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  wire [17:0] a;
  wire [3:0]  srbs;
  wire        ce, we, oe;
  wire [7:0]  st;
  wire [31:0] dbus;

  always #10 clk = ~clk;

  sram_test_core #(.ADDR_LAST(ADDR_LAST), .ACCESS_CYCLES(ACC)) dut (
    .CLK_48MHZ(clk), .RESET_IN_L8(rst_n),
    .SRAM_A0(a[0]), .SRAM_A1(a[1]), .SRAM_A2(a[2]), .SRAM_A3(a[3]), .SRAM_A4(a[4]), .SRAM_A5(a[5]),
    .SRAM_A6(a[6]), .SRAM_A7(a[7]), .SRAM_A8(a[8]), .SRAM_A9(a[9]), .SRAM_A10(a[10]), .SRAM_A11(a[11]),
    .SRAM_A12(a[12]), .SRAM_A13(a[13]), .SRAM_A14(a[14]), .SRAM_A15(a[15]), .SRAM_A16(a[16]),
    .SRAM_A17(a[17]),
    .SRAM_SRBS0(srbs[0]), .SRAM_SRBS1(srbs[1]), .SRAM_SRBS2(srbs[2]), .SRAM_SRBS3(srbs[3]),
    .SRAM_CE(ce), .SRAM_WE(we), .SRAM_OE(oe),
    .D0(st[0]), .D1(st[1]), .D2(st[2]), .D3(st[3]), .D4(st[4]), .D5(st[5]), .D6(st[6]), .D7(st[7]),
    .SRAM_D0(dbus[0]), .SRAM_D1(dbus[1]), .SRAM_D2(dbus[2]), .SRAM_D3(dbus[3]),
    .SRAM_D4(dbus[4]), .SRAM_D5(dbus[5]), .SRAM_D6(dbus[6]), .SRAM_D7(dbus[7]),
    .SRAM_D8(dbus[8]), .SRAM_D9(dbus[9]), .SRAM_D10(dbus[10]), .SRAM_D11(dbus[11]),
    .SRAM_D12(dbus[12]), .SRAM_D13(dbus[13]), .SRAM_D14(dbus[14]), .SRAM_D15(dbus[15]),
    .SRAM_D16(dbus[16]), .SRAM_D17(dbus[17]), .SRAM_D18(dbus[18]), .SRAM_D19(dbus[19]),
    .SRAM_D20(dbus[20]), .SRAM_D21(dbus[21]), .SRAM_D22(dbus[22]), .SRAM_D23(dbus[23]),
    .SRAM_D24(dbus[24]), .SRAM_D25(dbus[25]), .SRAM_D26(dbus[26]), .SRAM_D27(dbus[27]),
    .SRAM_D28(dbus[28]), .SRAM_D29(dbus[29]), .SRAM_D30(dbus[30]), .SRAM_D31(dbus[31])
  );

  typedef struct packed { logic [17:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [7:0] status; logic [15:0] cyc; } st_t;
  wr_t exp_wr_q[$];
  st_t exp_st_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int unsigned cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural SRAM: mode 0 normal, 1 bit 3 of addr 7 stuck at 1, 2 reads return zero.
  logic [31:0] mem [16];
  int          mode = 0;
  logic [31:0] rd_val;
  wire         mdl_en = !ce && !oe && we;

  always_comb begin
    rd_val = mem[a[3:0]];
    if (mode == 2) rd_val = '0;
    else if (mode == 1 && a == 18'd7) rd_val[3] = 1'b1;
  end
  assign dbus = mdl_en ? rd_val : 32'bz;

  always @(posedge we) begin
    if (!ce)
      for (int b = 0; b < 4; b++)
        if (!srbs[b]) mem[a[3:0]][8*b +: 8] <= dbus[8*b +: 8];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: pops expected writes on each completed WE pulse and expected status on D7 rising.
  always @(negedge clk) begin : mon
    logic        we_prev, d7_prev;
    int          wlen;
    logic [17:0] wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    wr_t         ew;
    st_t         es;
    if (!rst_n) begin
      we_prev = 1'b1;
      d7_prev = 1'b0;
      wlen    = 0;
    end else begin
      chk("we_oe_overlap", 32'(!we && !oe), 32'd0);
      if (!we) begin
        if (we_prev) begin
          wa = a; wd = dbus; ws = srbs; wlen = 1;
        end else begin
          wlen++;
        end
      end else if (!we_prev) begin
        chk("write_expected", 32'(exp_wr_q.size() != 0), 32'd1);
        if (exp_wr_q.size() != 0) begin
          ew = exp_wr_q.pop_front();
          chk("wr_addr", 32'(wa), 32'(ew.addr));
          chk("wr_data", wd, ew.data);
          chk("wr_srbs", 32'(ws), 32'd0);
          chk("wr_pulse_len", 32'(wlen), 32'(ACC));
        end
      end
      if (st[7] && !d7_prev) begin
        chk("status_expected", 32'(exp_st_q.size() != 0), 32'd1);
        if (exp_st_q.size() != 0) begin
          es = exp_st_q.pop_front();
          chk("done_status", 32'(st), 32'(es.status));
          chk("done_cycle", 32'(cyc), 32'(es.cyc));
        end
        done_cnt++;
      end
      we_prev = we;
      d7_prev = st[7];
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rst_ctl"},    32'({ce, we, oe}), 32'h7);
    chk({tag, "_rst_srbs"},   32'(srbs), 32'hF);
    chk({tag, "_rst_addr"},   32'(a), 32'd0);
    chk({tag, "_rst_status"}, 32'(st), 32'd0);
  endtask

  task automatic start_run(input int m, input logic [7:0] exp_status, input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    mode = m;
    exp_wr_q.delete();
    exp_st_q.delete();
    for (int i = 0; i < 16; i++) exp_wr_q.push_back('{addr: 18'(i), data: WDATA[i]});
    exp_st_q.push_back('{status: exp_status, cyc: 16'd129});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic finish_run(input logic [7:0] exp_status, input string tag);
    int start;
    start = done_cnt;
    for (int k = 0; k < 400 && done_cnt == start; k++) @(negedge clk);
    chk({tag, "_done_seen"}, 32'(done_cnt != start), 32'd1);
    repeat (5) @(negedge clk);
    chk({tag, "_status_hold"}, 32'(st), 32'(exp_status));
    chk({tag, "_addr_hold"},   32'(a), 32'(ADDR_LAST));
    chk({tag, "_done_ctl"},    32'({ce, we, oe, srbs}), 32'h7F);
    chk({tag, "_wr_drained"},  32'(exp_wr_q.size()), 32'd0);
  endtask

  initial begin
    bit found;
    start_run(0, 8'hC0, "clean");
    finish_run(8'hC0, "clean");
    start_run(1, 8'hA1, "stuck");
    finish_run(8'hA1, "stuck");
    start_run(2, 8'hAF, "sat");
    finish_run(8'hAF, "sat");

    // Reset in the middle of the read of address 9, then a clean restart.
    start_run(0, 8'hC0, "mid");
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (a == 18'd9 && !oe && !ce) found = 1'b1;
    end
    chk("mid_read9_seen", 32'(found), 32'd1);
    chk("mid_wr_drained", 32'(exp_wr_q.size()), 32'd0);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("mid_async");
    start_run(0, 8'hC0, "restart");
    finish_run(8'hC0, "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
